wshb_qos_arbiter: RTL

//  Two-master Wishbone B4 (pipelined) arbiter sharing the single wb16_sdram16 slave.

---
 rtl/wshb_qos_arbiter_if.sv | 28 ++
 rtl/wshb_qos_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wshb_qos_arbiter_if.sv
// Pipelined Wishbone B4 link between one master and one slave.
// A request transfers on a cycle with cyc & stb & !stall; each transferred request gets exactly one later ack.
interface wshb_qos_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  localparam int SEL_W = DATA_W / 8;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_ms;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] dat_sm;
  logic              ack;
  logic              stall;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel,
    input  dat_sm, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel,
    output dat_sm, ack, stall
  );
endinterface

// File: rtl/wshb_qos_arbiter.sv
// Two-master pipelined Wishbone arbiter: master 0 has priority, a per-grant quota with a
// drain phase hands the bus over only once every accepted request has been acked.
module wshb_qos_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int QUOTA   = 64,
  parameter int MAX_OUT = 8
) (
  input  logic                           wshb_clk,
  input  logic                           wshb_rst,
  wshb_qos_arbiter_if.slave              m0,
  wshb_qos_arbiter_if.slave              m1,
  wshb_qos_arbiter_if.master             s,
  output logic                           err_ack,
  output logic [1:0]                     dbg_state,
  output logic [$clog2(MAX_OUT+1)-1:0]   dbg_out_cnt
);
  localparam int SEL_W = DATA_W / 8;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int Q_W   = $clog2(QUOTA + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [Q_W-1:0]   QUOTA_C   = Q_W'(QUOTA);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             prev_owner_q, prev_owner_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic [Q_W-1:0]   quota_cnt_q, quota_cnt_d;
  logic             err_ack_q, err_ack_d;

  logic              sel_m1;
  logic              own_cyc, own_stb, other_cyc;
  logic              req_we;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_dat;
  logic [SEL_W-1:0]  req_sel;
  logic              limit, accept;

  // In DRAIN the previous owner stays selected so its late acks still reach it.
  always_comb begin
    sel_m1 = 1'b0;
    case (state_q)
      OWN1:    sel_m1 = 1'b1;
      DRAIN:   sel_m1 = prev_owner_q;
      default: sel_m1 = 1'b0;
    endcase
    own_cyc   = sel_m1 ? m1.cyc    : m0.cyc;
    own_stb   = sel_m1 ? m1.stb    : m0.stb;
    other_cyc = sel_m1 ? m0.cyc    : m1.cyc;
    req_we    = sel_m1 ? m1.we     : m0.we;
    req_adr   = sel_m1 ? m1.adr    : m0.adr;
    req_dat   = sel_m1 ? m1.dat_ms : m0.dat_ms;
    req_sel   = sel_m1 ? m1.sel    : m0.sel;
  end

  assign limit  = (out_cnt_q == MAX_OUT_C);
  assign accept = s.stb & ~s.stall;

  always_comb begin
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    s.we      = 1'b0;
    s.adr     = '0;
    s.dat_ms  = '0;
    s.sel     = '0;
    m0.stall  = 1'b1;
    m1.stall  = 1'b1;
    m0.ack    = 1'b0;
    m1.ack    = 1'b0;
    m0.dat_sm = s.dat_sm;
    m1.dat_sm = s.dat_sm;
    case (state_q)
      OWN0, OWN1: begin
        s.cyc    = own_cyc;
        s.stb    = own_stb & ~limit;
        s.we     = req_we;
        s.adr    = req_adr;
        s.dat_ms = req_dat;
        s.sel    = req_sel;
        if (sel_m1) begin
          m1.stall = s.stall | limit;
          m1.ack   = s.ack;
        end else begin
          m0.stall = s.stall | limit;
          m0.ack   = s.ack;
        end
      end
      DRAIN: begin
        s.cyc    = 1'b1;
        s.we     = req_we;
        s.adr    = req_adr;
        s.dat_ms = req_dat;
        s.sel    = req_sel;
        if (sel_m1) m1.ack = s.ack;
        else        m0.ack = s.ack;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    prev_owner_d = prev_owner_q;
    quota_cnt_d  = quota_cnt_q;
    out_cnt_d    = out_cnt_q;
    err_ack_d    = err_ack_q;

    if (s.ack && (out_cnt_q == '0)) err_ack_d = 1'b1;
    // A spurious ack never decrements; it does not cancel a request accepted alongside it.
    case ({accept, s.ack})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   if (out_cnt_q != '0) out_cnt_d = out_cnt_q - 1'b1;
      2'b11:   if (out_cnt_q == '0) out_cnt_d = out_cnt_q + 1'b1;
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        quota_cnt_d = '0;
        if (m0.cyc)      state_d = OWN0;
        else if (m1.cyc) state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (accept && other_cyc && (quota_cnt_q != QUOTA_C))
          quota_cnt_d = quota_cnt_q + 1'b1;
        // Using the post-accept count stops the owner right after its last allowed request.
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (other_cyc && (quota_cnt_d == QUOTA_C)) begin
          state_d      = DRAIN;
          prev_owner_d = sel_m1;
        end
      end
      DRAIN: begin
        quota_cnt_d = '0;
        if (out_cnt_d == '0) begin
          if (!other_cyc)        state_d = IDLE;
          else if (prev_owner_q) state_d = OWN0;
          else                   state_d = OWN1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wshb_clk or posedge wshb_rst) begin
    if (wshb_rst) begin
      state_q      <= IDLE;
      prev_owner_q <= 1'b0;
      out_cnt_q    <= '0;
      quota_cnt_q  <= '0;
      err_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_owner_q <= prev_owner_d;
      out_cnt_q    <= out_cnt_d;
      quota_cnt_q  <= quota_cnt_d;
      err_ack_q    <= err_ack_d;
    end
  end

  assign err_ack     = err_ack_q;
  assign dbg_state   = state_q;
  assign dbg_out_cnt = out_cnt_q;
endmodule
